jmp_irq_control_unit: RTL and testbench

- Parametrised successor to the single-interrupt jump control path.
- Resolves control flow for the program-memory stage each cycle: unconditional jump, flag-conditional branches, and vectored interrupts with NUM_IRQ prioritised lines.
- Also covers return-from-interrupt with saved PC/flags, and a configurable flush-stall after every redirect.
- Sits between the decode/execute stages and program_memory_block, driving jmp_loc, pc_mux_sel and stall.

---
 rtl/jmp_irq_control_unit.sv | 165 ++++++++++++++++
 tb/tb_jmp_irq_control_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jmp_irq_control_unit.sv
// Control-flow resolver for the program-memory stage: jumps, flag branches,
// prioritised vectored interrupts with RETI, and a fixed flush-stall after each redirect.
module jmp_irq_control_unit #(
  parameter int                ADDR_W       = 16,
  parameter int                OP_W         = 6,
  parameter int                NUM_IRQ      = 4,
  parameter logic [ADDR_W-1:0] VEC_BASE     = 16'h0100,
  parameter int                VEC_STRIDE   = 4,
  parameter int                FLUSH_CYCLES = 2,
  parameter logic [OP_W-1:0]   OP_JMP       = 6'd12,
  parameter logic [OP_W-1:0]   OP_JZ        = 6'd13,
  parameter logic [OP_W-1:0]   OP_JC        = 6'd14,
  parameter logic [OP_W-1:0]   OP_RETI      = 6'd15,
  parameter logic [OP_W-1:0]   OP_EI        = 6'd16,
  parameter logic [OP_W-1:0]   OP_DI        = 6'd17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [ADDR_W-1:0]  jmp_addr,
  input  logic [ADDR_W-1:0]  cur_addr,
  input  logic [1:0]         flag_ex,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [ADDR_W-1:0]  jmp_loc,
  output logic               pc_mux_sel,
  output logic               stall,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               in_isr,
  output logic               flag_restore,
  output logic [1:0]         saved_flags
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t             state, state_next;
  logic [3:0]         cnt, cnt_next;
  logic               ie, ie_next;
  logic [NUM_IRQ-1:0] pending, pending_next;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] rise, eff_pending, grant, clr;
  logic [ADDR_W-1:0]  saved_pc, saved_pc_next;
  logic [ADDR_W-1:0]  vec_sel, target;
  logic [ADDR_W-1:0]  jmp_loc_next;
  logic               pc_mux_sel_next, stall_next, in_isr_next, flag_restore_next;
  logic [NUM_IRQ-1:0] irq_ack_next;
  logic [1:0]         saved_flags_next;
  logic               redirect;

  // Vector addresses are constants; the sum is formed wide and truncated so it wraps.
  logic [ADDR_W-1:0] vec_table [NUM_IRQ];
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_vec
    localparam logic [31:0] VEC_ADDR = 32'(VEC_BASE) + 32'(gi) * 32'(VEC_STRIDE);
    assign vec_table[gi] = VEC_ADDR[ADDR_W-1:0];
  end

  // A fresh edge counts in the same cycle so it can pre-empt a coincident jump.
  always_comb begin
    rise        = irq & ~irq_prev;
    eff_pending = pending | rise;
    grant       = eff_pending & (~eff_pending + NUM_IRQ'(1));
    vec_sel     = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (grant[i]) vec_sel = vec_sel | vec_table[i];
    end
  end

  always_comb begin
    state_next        = state;
    cnt_next          = cnt;
    ie_next           = ie;
    in_isr_next       = in_isr;
    saved_pc_next     = saved_pc;
    saved_flags_next  = saved_flags;
    jmp_loc_next      = jmp_loc;
    pc_mux_sel_next   = 1'b0;
    stall_next        = 1'b0;
    irq_ack_next      = '0;
    flag_restore_next = 1'b0;
    clr               = '0;
    redirect          = 1'b0;
    target            = jmp_loc;

    case (state)
      RUN: begin
        if (ie && !in_isr && (|eff_pending)) begin
          redirect         = 1'b1;
          target           = vec_sel;
          saved_pc_next    = cur_addr;
          saved_flags_next = flag_ex;
          in_isr_next      = 1'b1;
          irq_ack_next     = grant;
          clr              = grant;
        end else if (op == OP_RETI && in_isr) begin
          redirect          = 1'b1;
          target            = saved_pc;
          in_isr_next       = 1'b0;
          flag_restore_next = 1'b1;
        end else if (op == OP_JMP || (op == OP_JZ && flag_ex[0]) ||
                     (op == OP_JC && flag_ex[1])) begin
          redirect = 1'b1;
          target   = jmp_addr;
        end else if (op == OP_EI) begin
          ie_next = 1'b1;
        end else if (op == OP_DI) begin
          ie_next = 1'b0;
        end

        if (redirect) begin
          jmp_loc_next    = target;
          pc_mux_sel_next = 1'b1;
          stall_next      = 1'b1;
          state_next      = FLUSH;
          cnt_next        = CNT_INIT;
        end
      end
      FLUSH: begin
        stall_next = 1'b1;
        if (cnt == 4'd0) begin
          state_next = RUN;
          stall_next = 1'b0;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: state_next = RUN;
    endcase

    pending_next = eff_pending & ~clr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      cnt          <= '0;
      ie           <= 1'b0;
      pending      <= '0;
      irq_prev     <= '0;
      saved_pc     <= '0;
      saved_flags  <= '0;
      jmp_loc      <= '0;
      pc_mux_sel   <= 1'b0;
      stall        <= 1'b0;
      irq_ack      <= '0;
      in_isr       <= 1'b0;
      flag_restore <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      ie           <= ie_next;
      pending      <= pending_next;
      irq_prev     <= irq;
      saved_pc     <= saved_pc_next;
      saved_flags  <= saved_flags_next;
      jmp_loc      <= jmp_loc_next;
      pc_mux_sel   <= pc_mux_sel_next;
      stall        <= stall_next;
      irq_ack      <= irq_ack_next;
      in_isr       <= in_isr_next;
      flag_restore <= flag_restore_next;
    end
  end

endmodule

// File: tb/tb_jmp_irq_control_unit.sv
// Directed plus randomized bench for jmp_irq_control_unit, checked against a
// cycle-level reference model that tracks pending requests and remaining stall cycles.
module tb_jmp_irq_control_unit;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_JMP  = 6'd12;
  localparam logic [5:0] OP_JZ   = 6'd13;
  localparam logic [5:0] OP_JC   = 6'd14;
  localparam logic [5:0] OP_RETI = 6'd15;
  localparam logic [5:0] OP_EI   = 6'd16;
  localparam logic [5:0] OP_DI   = 6'd17;
  localparam int         FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  op = OP_NOP;
  logic [15:0] jmp_addr = '0;
  logic [15:0] cur_addr = '0;
  logic [1:0]  flag_ex = '0;
  logic [3:0]  irq = '0;

  logic [15:0] jmp_loc, b_jmp_loc;
  logic        pc_mux_sel, stall, in_isr, flag_restore;
  logic        b_pc_mux_sel, b_stall, b_in_isr, b_flag_restore;
  logic [3:0]  irq_ack, b_irq_ack;
  logic [1:0]  saved_flags, b_saved_flags;

  int compared = 0;
  int mism = 0;

  // reference model state
  bit          m_ie, m_in_isr;
  logic [3:0]  m_pend, m_prev;
  logic [15:0] m_saved_pc;
  logic [1:0]  m_saved_flags;
  int          m_flush;
  logic [15:0] e_jmp_a, e_jmp_b;
  logic        e_pcsel, e_stall, e_frest;
  logic [3:0]  e_ack;

  jmp_irq_control_unit dut_a (
    .clk(clk), .reset(reset), .op(op), .jmp_addr(jmp_addr), .cur_addr(cur_addr),
    .flag_ex(flag_ex), .irq(irq), .jmp_loc(jmp_loc), .pc_mux_sel(pc_mux_sel),
    .stall(stall), .irq_ack(irq_ack), .in_isr(in_isr), .flag_restore(flag_restore),
    .saved_flags(saved_flags)
  );

  jmp_irq_control_unit #(.VEC_BASE(16'hFFFC)) dut_b (
    .clk(clk), .reset(reset), .op(op), .jmp_addr(jmp_addr), .cur_addr(cur_addr),
    .flag_ex(flag_ex), .irq(irq), .jmp_loc(b_jmp_loc), .pc_mux_sel(b_pc_mux_sel),
    .stall(b_stall), .irq_ack(b_irq_ack), .in_isr(b_in_isr), .flag_restore(b_flag_restore),
    .saved_flags(b_saved_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ie = 0; m_in_isr = 0; m_pend = '0; m_prev = '0; m_saved_pc = '0;
    m_saved_flags = '0; m_flush = 0; e_jmp_a = '0; e_jmp_b = '0;
    e_pcsel = 0; e_stall = 0; e_frest = 0; e_ack = '0;
  endtask

  // One clock edge of the reference behaviour, using the inputs present at that edge.
  task automatic model_step();
    logic [3:0]  avail;
    logic [15:0] tgt;
    int          k;
    bit          redir;
    avail   = m_pend | (irq & ~m_prev);
    m_prev  = irq;
    e_pcsel = 0; e_ack = '0; e_frest = 0; redir = 0; tgt = '0;
    if (m_flush > 0) begin
      m_flush--;
    end else begin
      if (m_ie && !m_in_isr && avail != 0) begin
        k = 0;
        for (int i = 3; i >= 0; i--) if (avail[i]) k = i;
        m_saved_pc = cur_addr; m_saved_flags = flag_ex; m_in_isr = 1;
        e_ack = 4'(1 << k); avail[k] = 1'b0;
        e_jmp_a = 16'(32'h0100 + 4 * k);
        e_jmp_b = 16'(32'hFFFC + 4 * k);
        e_pcsel = 1; m_flush = FLUSH_CYCLES;
      end else if (op == OP_RETI && m_in_isr) begin
        tgt = m_saved_pc; m_in_isr = 0; e_frest = 1; redir = 1;
      end else if (op == OP_JMP || (op == OP_JZ && flag_ex[0]) || (op == OP_JC && flag_ex[1])) begin
        tgt = jmp_addr; redir = 1;
      end else if (op == OP_EI) begin
        m_ie = 1;
      end else if (op == OP_DI) begin
        m_ie = 0;
      end
      if (redir) begin
        e_jmp_a = tgt; e_jmp_b = tgt; e_pcsel = 1; m_flush = FLUSH_CYCLES;
      end
    end
    m_pend  = avail;
    e_stall = (m_flush > 0);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".jmp_loc"},      32'(jmp_loc),      32'(e_jmp_a));
    chk({tag, ".b_jmp_loc"},    32'(b_jmp_loc),    32'(e_jmp_b));
    chk({tag, ".pc_mux_sel"},   32'(pc_mux_sel),   32'(e_pcsel));
    chk({tag, ".stall"},        32'(stall),        32'(e_stall));
    chk({tag, ".irq_ack"},      32'(irq_ack),      32'(e_ack));
    chk({tag, ".in_isr"},       32'(in_isr),       32'(m_in_isr));
    chk({tag, ".flag_restore"}, 32'(flag_restore), 32'(e_frest));
    chk({tag, ".saved_flags"},  32'(saved_flags),  32'(m_saved_flags));
    chk({tag, ".b_stall"},      32'(b_stall),      32'(e_stall));
    chk({tag, ".b_irq_ack"},    32'(b_irq_ack),    32'(e_ack));
    chk({tag, ".b_in_isr"},     32'(b_in_isr),     32'(m_in_isr));
    chk({tag, ".b_frest"},      32'(b_flag_restore), 32'(e_frest));
    chk({tag, ".b_sflags"},     32'(b_saved_flags), 32'(m_saved_flags));
    chk({tag, ".b_pcsel"},      32'(b_pc_mux_sel), 32'(e_pcsel));
  endtask

  task automatic step(input logic [5:0] o, input logic [15:0] ja, input logic [15:0] ca,
                      input logic [1:0] fl, input string tag);
    op = o; jmp_addr = ja; cur_addr = ca; flag_ex = fl;
    @(posedge clk);
    if (reset) model_step();
    #1;
    check_all(tag);
    $display("%s: op=%0d irq=%b jmp_loc=%h pcsel=%b stall=%b ack=%b isr=%b",
             tag, o, irq, jmp_loc, pc_mux_sel, stall, irq_ack, in_isr);
  endtask

  task automatic nop(input string tag);
    step(OP_NOP, 16'h0000, 16'h0000, 2'b00, tag);
  endtask

  initial begin
    model_reset();

    // reset with active-looking inputs
    irq = 4'hF;
    step(OP_JMP, 16'h0040, 16'h0000, 2'b00, "rst0");
    step(OP_JMP, 16'h0040, 16'h0000, 2'b00, "rst1");
    chk("rst.jmp_loc", 32'(jmp_loc), 32'h0);
    chk("rst.stall",   32'(stall),   32'h0);

    reset = 1'b1;
    nop("rel");
    step(OP_EI, 16'h0000, 16'h0000, 2'b00, "ei");
    chk("ei.no_redirect", 32'(pc_mux_sel), 32'h0);
    chk("ei.no_ack",      32'(irq_ack),    32'h0);
    step(OP_NOP, 16'h0000, 16'h0020, 2'b00, "take0");
    chk("take0.ack", 32'(irq_ack), 32'h1);
    chk("take0.loc", 32'(jmp_loc), 32'h0100);
    for (int k = 1; k <= 4; k++) begin
      nop("isr_f0"); nop("isr_f1");
      step(OP_RETI, 16'h0000, 16'h0000, 2'b00, "reti");
      chk("reti.frest", 32'(flag_restore), 32'h1);
      nop("reti_f0"); nop("reti_f1");
      if (k < 4) begin
        step(OP_NOP, 16'h0000, 16'(16'h0020 + k), 2'b00, "take_next");
        chk("take_next.ack", 32'(irq_ack), 32'(1 << k));
      end
    end
    irq = 4'h0;

    // unconditional jump, then a jump during stall
    step(OP_JMP, 16'h0040, 16'h0005, 2'b00, "jmp");
    chk("jmp.loc", 32'(jmp_loc), 32'h0040);
    chk("jmp.pcsel", 32'(pc_mux_sel), 32'h1);
    step(OP_JMP, 16'h0099, 16'h0006, 2'b00, "jmp_in_stall");
    chk("jmp_in_stall.loc", 32'(jmp_loc), 32'h0040);
    chk("jmp_in_stall.stall", 32'(stall), 32'h1);
    nop("jmp_end");
    chk("jmp_end.stall", 32'(stall), 32'h0);

    // branches
    step(OP_JZ, 16'h0080, 16'h0007, 2'b01, "jz_taken");
    chk("jz_taken.loc", 32'(jmp_loc), 32'h0080);
    nop("jz_f0"); nop("jz_f1");
    step(OP_JC, 16'h0090, 16'h0008, 2'b01, "jc_not");
    chk("jc_not.pcsel", 32'(pc_mux_sel), 32'h0);
    chk("jc_not.stall", 32'(stall), 32'h0);
    step(OP_RETI, 16'h0000, 16'h0009, 2'b00, "reti_noisr");
    chk("reti_noisr.pcsel", 32'(pc_mux_sel), 32'h0);

    // priority: lines 1 and 2 rise together; wrap check on the high-base instance
    irq = 4'b0110;
    step(OP_NOP, 16'h0000, 16'h0033, 2'b10, "prio");
    chk("prio.loc", 32'(jmp_loc), 32'h0104);
    chk("prio.ack", 32'(irq_ack), 32'b0010);
    chk("prio.sflags", 32'(saved_flags), 32'b10);
    chk("wrap.b_loc", 32'(b_jmp_loc), 32'h0000);
    nop("prio_f0"); nop("prio_f1");
    step(OP_RETI, 16'h0000, 16'h0070, 2'b00, "prio_reti");
    chk("prio_reti.loc", 32'(jmp_loc), 32'h0033);
    nop("prio_rf0"); nop("prio_rf1");
    nop("prio2");
    chk("prio2.ack", 32'(irq_ack), 32'b0100);
    chk("prio2.loc", 32'(jmp_loc), 32'h0108);
    nop("p2_f0"); nop("p2_f1");
    step(OP_RETI, 16'h0000, 16'h0000, 2'b00, "p2_reti");
    nop("p2_rf0"); nop("p2_rf1");

    // collision of a fresh edge with a jump
    irq = 4'b0000;
    nop("col_idle");
    irq = 4'b0001;
    step(OP_JMP, 16'h0200, 16'h0010, 2'b00, "collide");
    chk("collide.loc", 32'(jmp_loc), 32'h0100);
    nop("col_f0"); nop("col_f1");
    step(OP_RETI, 16'h0000, 16'h0000, 2'b00, "col_reti");
    chk("col_reti.loc", 32'(jmp_loc), 32'h0010);
    nop("col_rf0"); nop("col_rf1");

    // edge arriving during flush
    step(OP_JMP, 16'h0050, 16'h0011, 2'b00, "fl_jmp");
    irq = 4'b1001;
    nop("fl_edge");
    chk("fl_edge.ack", 32'(irq_ack), 32'h0);
    nop("fl_last");
    nop("fl_take");
    chk("fl_take.ack", 32'(irq_ack), 32'b1000);
    chk("fl_take.loc", 32'(jmp_loc), 32'h010C);
    nop("fl_f0"); nop("fl_f1");
    step(OP_RETI, 16'h0000, 16'h0000, 2'b00, "fl_reti");
    nop("fl_rf0"); nop("fl_rf1");

    // asynchronous reset in the middle of a flush
    step(OP_JMP, 16'h0060, 16'h0012, 2'b00, "mid_jmp");
    reset = 1'b0;
    #1;
    model_reset();
    chk("mid_reset.stall", 32'(stall), 32'h0);
    check_all("mid_reset");
    nop("mid_hold");
    reset = 1'b1;

    // randomized phase
    step(OP_EI, 16'h0000, 16'h0000, 2'b00, "rnd_ei");
    for (int n = 0; n < 400; n++) begin
      logic [5:0] o;
      case ($urandom_range(0, 9))
        0: o = OP_JMP;
        1: o = OP_JZ;
        2: o = OP_JC;
        3, 4: o = OP_RETI;
        5: o = OP_EI;
        6: o = OP_DI;
        default: o = 6'($urandom_range(0, 11));
      endcase
      if ($urandom_range(0, 5) == 0) irq = irq ^ 4'(1 << $urandom_range(0, 3));
      step(o, 16'($urandom), 16'($urandom), 2'($urandom), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
